// File: rtl/sr_entry_ctrl.sv
// Bit-entry sequencer for the 7-bit pattern-detect shift register: arbitrates
// button requests, drives din/enable, stretches matches and flushes on match/timeout.
module sr_entry_ctrl #(
  parameter int SR_LEN      = 7,
  parameter int TIMEOUT_CYC = 500000000,
  parameter int HOLD_CYC    = 100000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn1_req,
  input  logic                          btn0_req,
  input  logic                          sr_match,
  output logic                          sr_din,
  output logic                          sr_enable,
  output logic [$clog2(SR_LEN+1)-1:0]   bit_count,
  output logic                          busy,
  output logic                          match_hold,
  output logic                          collision,
  output logic                          overflow
);

  localparam int BW = $clog2(SR_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [BW-1:0] BC_ZERO    = {BW{1'b0}};
  localparam logic [BW-1:0] BC_ONE     = BW'(32'd1);
  localparam logic [BW-1:0] BC_MAX     = BW'(SR_LEN);
  localparam logic [BW-1:0] FLUSH_LAST = BW'(SR_LEN - 1);
  localparam logic [TW-1:0] TM_ZERO    = {TW{1'b0}};
  localparam logic [TW-1:0] TM_ONE     = TW'(32'd1);
  localparam logic [TW-1:0] TM_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HD_ZERO    = {HW{1'b0}};
  localparam logic [HW-1:0] HD_ONE     = HW'(32'd1);
  localparam logic [HW-1:0] HD_LAST    = HW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4,
    FLUSH = 3'd5
  } state_t;

  state_t          state_r, next_state_s;
  logic            data_r, data_nxt_s;
  logic            pend_valid_r, pend_valid_nxt_s;
  logic            pend_bit_r, pend_bit_nxt_s;
  logic            overflow_r, overflow_nxt_s;
  logic [BW-1:0]   bit_count_r, bit_count_nxt_s;
  logic [BW-1:0]   flush_cnt_r, flush_cnt_nxt_s;
  logic [TW-1:0]   timer_r, timer_nxt_s;
  logic [HW-1:0]   hold_cnt_r, hold_cnt_nxt_s;
  logic            sr_din_r, sr_enable_r, busy_r, match_hold_r, collision_r;
  logic            req_valid_s, req_bit_s;
  logic            din_nxt_s;

  assign req_valid_s = btn1_req ^ btn0_req;
  assign req_bit_s   = btn1_req;

  // Next-state, pending-slot, counter and overflow decode
  always_comb begin
    next_state_s     = state_r;
    data_nxt_s       = data_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_bit_nxt_s   = pend_bit_r;
    overflow_nxt_s   = overflow_r;
    bit_count_nxt_s  = bit_count_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    timer_nxt_s      = timer_r;
    hold_cnt_nxt_s   = hold_cnt_r;

    case (state_r)
      IDLE: begin
        if (pend_valid_r) begin
          // Serve the buffered bit; a same-cycle request refills the slot.
          next_state_s = LOAD;
          data_nxt_s   = pend_bit_r;
          timer_nxt_s  = TM_ZERO;
          if (req_valid_s) begin
            pend_bit_nxt_s = req_bit_s;
          end else begin
            pend_valid_nxt_s = 1'b0;
          end
        end else if (req_valid_s) begin
          next_state_s = LOAD;
          data_nxt_s   = req_bit_s;
          timer_nxt_s  = TM_ZERO;
        end else if (bit_count_r != BC_ZERO) begin
          if (timer_r == TM_LAST) begin
            next_state_s    = FLUSH;
            flush_cnt_nxt_s = BC_ZERO;
          end else begin
            timer_nxt_s = timer_r + TM_ONE;
          end
        end else begin
          timer_nxt_s = TM_ZERO;
        end
      end
      LOAD: begin
        next_state_s = SHIFT;
      end
      SHIFT: begin
        next_state_s = CHECK;
        if (bit_count_r != BC_MAX) begin
          bit_count_nxt_s = bit_count_r + BC_ONE;
        end else begin
          bit_count_nxt_s = bit_count_r;
        end
      end
      CHECK: begin
        if (sr_match) begin
          next_state_s   = HOLD;
          hold_cnt_nxt_s = HD_ZERO;
        end else begin
          next_state_s = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_r == HD_LAST) begin
          next_state_s    = FLUSH;
          flush_cnt_nxt_s = BC_ZERO;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HD_ONE;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) begin
          next_state_s    = IDLE;
          bit_count_nxt_s = BC_ZERO;
          timer_nxt_s     = TM_ZERO;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r + BC_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    // While busy, a request may only park in the single pending slot.
    if ((state_r != IDLE) && req_valid_s) begin
      if (!pend_valid_r) begin
        pend_valid_nxt_s = 1'b1;
        pend_bit_nxt_s   = req_bit_s;
      end else begin
        overflow_nxt_s = 1'b1;
      end
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  assign din_nxt_s = ((next_state_s == LOAD) || (next_state_s == SHIFT)) ? data_nxt_s : 1'b0;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      data_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_bit_r   <= 1'b0;
      overflow_r   <= 1'b0;
      bit_count_r  <= BC_ZERO;
      flush_cnt_r  <= BC_ZERO;
      timer_r      <= TM_ZERO;
      hold_cnt_r   <= HD_ZERO;
      sr_din_r     <= 1'b0;
      sr_enable_r  <= 1'b0;
      busy_r       <= 1'b0;
      match_hold_r <= 1'b0;
      collision_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      data_r       <= data_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_bit_r   <= pend_bit_nxt_s;
      overflow_r   <= overflow_nxt_s;
      bit_count_r  <= bit_count_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
      timer_r      <= timer_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      sr_din_r     <= din_nxt_s;
      sr_enable_r  <= (next_state_s == SHIFT) || (next_state_s == FLUSH);
      busy_r       <= (next_state_s != IDLE);
      match_hold_r <= (next_state_s == HOLD);
      collision_r  <= btn1_req & btn0_req;
    end
  end

  assign sr_din     = sr_din_r;
  assign sr_enable  = sr_enable_r;
  assign bit_count  = bit_count_r;
  assign busy       = busy_r;
  assign match_hold = match_hold_r;
  assign collision  = collision_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_sr_entry_ctrl.sv
// Directed bench for sr_entry_ctrl with a behavioural 7-bit detector
// (pattern 1010111) closing the loop on sr_din/sr_enable.
module tb_sr_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn1_req = 1'b0;
  logic       btn0_req = 1'b0;
  logic       sr_match;
  logic       sr_din, sr_enable, busy, match_hold, collision, overflow;
  logic [2:0] bit_count;
  logic [6:0] det_sr;
  logic [6:0] pattern = 7'b1010111;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       b;
    logic [2:0] bc;
  } bit_t;

  typedef struct {
    logic       b1;
    logic       b0;
    logic       busy;
    logic       en;
    logic       din;
    logic [2:0] bc;
    logic       ovf;
  } row_t;

  bit_t seq[7];
  row_t tab[8];

  always #5 clk = ~clk;

  sr_entry_ctrl #(.SR_LEN(7), .TIMEOUT_CYC(20), .HOLD_CYC(8)) dut (
    .clk(clk), .rst(rst), .btn1_req(btn1_req), .btn0_req(btn0_req),
    .sr_match(sr_match), .sr_din(sr_din), .sr_enable(sr_enable),
    .bit_count(bit_count), .busy(busy), .match_hold(match_hold),
    .collision(collision), .overflow(overflow)
  );

  // Detector model: shifts din into the LSB on each enabled edge
  always @(posedge clk or negedge rst) begin
    if (!rst) det_sr <= 7'd0;
    else if (sr_enable) det_sr <= {det_sr[5:0], sr_din};
  end
  assign sr_match = (det_sr == pattern);

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; btn1_req = 1'b0; btn0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Pulse one request at a negedge; ends at the negedge inside CHECK.
  task automatic enter_bit(input logic b, input logic [2:0] exp_bc);
    btn1_req = b; btn0_req = ~b;
    @(negedge clk);
    btn1_req = 1'b0; btn0_req = 1'b0;
    chk1("load_busy", busy, 1'b1);
    chk1("load_en", sr_enable, 1'b0);
    chk1("load_din", sr_din, b);
    @(negedge clk);
    chk1("shift_en", sr_enable, 1'b1);
    chk1("shift_din", sr_din, b);
    @(negedge clk);
    chk1("check_en", sr_enable, 1'b0);
    chkv("check_bc", {4'd0, bit_count}, {4'd0, exp_bc});
  endtask

  // Counts outputs from the current negedge while busy stays high.
  task automatic run_busy(input int max, output int en, output int hold, output int dhi,
                          output logic to);
    en = 0; hold = 0; dhi = 0; to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      if (sr_enable) en++;
      if (match_hold) hold++;
      if (sr_din) dhi++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   en, hold, dhi, n;
    logic to;

    seq[0] = '{1'b1, 3'd1}; seq[1] = '{1'b0, 3'd2}; seq[2] = '{1'b1, 3'd3};
    seq[3] = '{1'b0, 3'd4}; seq[4] = '{1'b1, 3'd5}; seq[5] = '{1'b1, 3'd6};
    seq[6] = '{1'b1, 3'd7};

    //           b1    b0    busy  en    din   bc    ovf
    tab[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    tab[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    tab[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
    tab[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    tab[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1};
    tab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1};
    tab[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
    tab[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};

    // Reset values
    @(negedge clk);
    chk1("rst_din", sr_din, 1'b0);
    chk1("rst_en", sr_enable, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_hold", match_hold, 1'b0);
    chk1("rst_coll", collision, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    chkv("rst_bc", {4'd0, bit_count}, 7'd0);
    rst = 1'b1;
    @(negedge clk);
    chk1("post_rst_busy", busy, 1'b0);

    // 1: full pattern entry, match, hold, flush
    for (int i = 0; i < 7; i++) begin
      enter_bit(seq[i].b, seq[i].bc);
      if (i < 6) begin
        @(negedge clk);
        chk1("s1_no_hold", match_hold, 1'b0);
        repeat (2) @(negedge clk);
      end
    end
    run_busy(60, en, hold, dhi, to);
    chk1("s1_timeout", to, 1'b0);
    chki("s1_hold_cycles", hold, 8);
    chki("s1_flush_shifts", en, 7);
    chki("s1_flush_din", dhi, 0);
    chkv("s1_bc", {4'd0, bit_count}, 7'd0);
    chk1("s1_busy", busy, 1'b0);
    chkv("s1_det_cleared", det_sr, 7'd0);

    // 2: inactivity timeout after a single bit
    do_reset();
    enter_bit(1'b1, 3'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) break;
      n++;
    end
    chki("s2_idle_cycles", n, 20);
    run_busy(40, en, hold, dhi, to);
    chk1("s2_timeout", to, 1'b0);
    chki("s2_flush_shifts", en, 7);
    chki("s2_hold", hold, 0);
    chki("s2_flush_din", dhi, 0);
    chkv("s2_bc", {4'd0, bit_count}, 7'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || sr_enable) n++;
    end
    chki("s2_no_timeout_at_zero", n, 0);

    // 3: collision
    btn1_req = 1'b1; btn0_req = 1'b1;
    @(negedge clk);
    btn1_req = 1'b0; btn0_req = 1'b0;
    chk1("s3_coll", collision, 1'b1);
    chk1("s3_busy", busy, 1'b0);
    chk1("s3_en", sr_enable, 1'b0);
    @(negedge clk);
    chk1("s3_coll_pulse", collision, 1'b0);
    chk1("s3_en2", sr_enable, 1'b0);
    chkv("s3_bc", {4'd0, bit_count}, 7'd0);

    // 4: back-to-back requests, buffering and overflow (cycle table)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      btn1_req = tab[i].b1; btn0_req = tab[i].b0;
      @(negedge clk);
      chk1($sformatf("s4_busy_%0d", i), busy, tab[i].busy);
      chk1($sformatf("s4_en_%0d", i), sr_enable, tab[i].en);
      chk1($sformatf("s4_din_%0d", i), sr_din, tab[i].din);
      chkv($sformatf("s4_bc_%0d", i), {4'd0, bit_count}, {4'd0, tab[i].bc});
      chk1($sformatf("s4_ovf_%0d", i), overflow, tab[i].ovf);
    end
    btn1_req = 1'b0; btn0_req = 1'b0;
    repeat (35) @(negedge clk);
    chk1("s4_ovf_sticky", overflow, 1'b1);
    chkv("s4_bc_after_flush", {4'd0, bit_count}, 7'd0);

    // 5: asynchronous reset in the middle of a flush
    do_reset();
    enter_bit(1'b1, 3'd1);
    for (int i = 0; i < 40; i++) begin
      if (sr_enable) break;
      @(negedge clk);
    end
    chk1("s5_flush_started", sr_enable, 1'b1);
    repeat (3) @(negedge clk);
    chkv("s5_det_3_shifts", det_sr, 7'b0001000);
    #1 rst = 1'b0;
    #1;
    chk1("s5_din", sr_din, 1'b0);
    chk1("s5_en", sr_enable, 1'b0);
    chk1("s5_busy", busy, 1'b0);
    chk1("s5_hold", match_hold, 1'b0);
    chk1("s5_ovf", overflow, 1'b0);
    chkv("s5_bc", {4'd0, bit_count}, 7'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    enter_bit(1'b1, 3'd1);
    @(negedge clk);
    chk1("s5_idle", busy, 1'b0);

    // 6: request during HOLD is entered after the flush
    do_reset();
    for (int i = 0; i < 7; i++) begin
      enter_bit(seq[i].b, seq[i].bc);
      if (i < 6) repeat (3) @(negedge clk);
    end
    @(negedge clk);
    chk1("s6_in_hold", match_hold, 1'b1);
    btn0_req = 1'b1;
    @(negedge clk);
    btn0_req = 1'b0;
    run_busy(60, en, hold, dhi, to);
    chk1("s6_timeout", to, 1'b0);
    chki("s6_hold_rest", hold, 7);
    chki("s6_flush_shifts", en, 7);
    chkv("s6_bc_flushed", {4'd0, bit_count}, 7'd0);
    @(negedge clk);
    chk1("s6_load_busy", busy, 1'b1);
    chk1("s6_load_din", sr_din, 1'b0);
    @(negedge clk);
    chk1("s6_shift_en", sr_enable, 1'b1);
    @(negedge clk);
    chkv("s6_bc", {4'd0, bit_count}, 7'd1);
    chk1("s6_ovf", overflow, 1'b0);
    chk1("s6_hold_off", match_hold, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
